id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage directly upstream of the execute ALU in the 5-stage MIPS core.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB; detects load-use hazards and requests an upstream stall.
- Drives the ALU operands data1/data2 and the 3-bit ALU control.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- CTRL_W, 3, ALU control width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- flush_i  in  1  load a bubble (branch taken)
- id_rs_addr_i  in  REG_AW  source register rs
- id_rt_addr_i  in  REG_AW  source register rt
- id_rd_addr_i  in  REG_AW  destination register rd
- id_rs_data_i  in  DATA_W  register-file rs value
- id_rt_data_i  in  DATA_W  register-file rt value
- id_imm_i  in  DATA_W  sign-extended immediate
- id_alusrc_i  in  1  1: data2 = immediate
- id_regdst_i  in  1  1: destination = rd, 0: destination = rt
- id_aluctrl_i  in  CTRL_W  ALU operation
- id_regwrite_i  in  1  control bit passed to later stages
- id_memread_i  in  1  control bit passed to later stages
- id_memwrite_i  in  1  control bit passed to later stages
- id_memtoreg_i  in  1  control bit passed to later stages
- exmem_regwrite_i  in  1  EX/MEM writes a register
- exmem_rd_i  in  REG_AW  EX/MEM destination
- exmem_data_i  in  DATA_W  EX/MEM ALU result
- memwb_regwrite_i  in  1  MEM/WB writes a register
- memwb_rd_i  in  REG_AW  MEM/WB destination
- memwb_data_i  in  DATA_W  MEM/WB writeback value
- stall_o  out  1  hold PC and IF/ID
- data1_o  out  DATA_W  ALU operand 1
- data2_o  out  DATA_W  ALU operand 2
- ALUCtrl_o  out  CTRL_W  ALU control
- ex_valid_o  out  1  EX holds a real instruction
- ex_wr_addr_o  out  REG_AW  resolved destination register
- ex_store_data_o  out  DATA_W  forwarded rt value, used for SW
- ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o  out  1 each  registered control bits

Behaviour:
- Reset: rst_i asserted clears every register immediately (asynchronous). All registered outputs go to 0 and ex_valid_o = 0.
- Latency: 1 cycle. Values on id_* at a rising edge appear on the ex_* outputs after that edge.
- Destination: ex_wr_addr_o = id_regdst_i ? rd : rt, resolved at capture.
- Bubble: valid = 0, all control bits = 0, address and data fields = 0.
  - Loaded when flush_i = 1, stall_o = 1, or id_valid_i = 0.
  - If flush and stall occur together, the result is still one bubble.
- Load-use stall: stall_o = id_valid_i & ex_valid_o & ex_memread_o & (ex_wr_addr_o != 0) & (ex_wr_addr_o == rs | ex_wr_addr_o == rt). This is combinational. It lasts exactly 1 cycle per load, because the bubble clears ex_memread_o.
- Forwarding is combinational in the EX cycle and acts on the registered rs/rt values:
  - Select EX/MEM when exmem_regwrite_i & exmem_rd_i != 0 & exmem_rd_i == the registered address.
  - Otherwise select MEM/WB under the same conditions using the memwb_* inputs.
  - Otherwise use the registered register-file value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- data1_o = forwarded rs.
- data2_o = alusrc ? imm : forwarded rt.
- ex_store_data_o = forwarded rt in all cases.
- ALUCtrl_o is the registered id_aluctrl_i. For a bubble it is 0 (AND), which is harmless.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: forwarding exactly as described in Behaviour.
- Undefined:
  - Forwarding muxes are removed; operands come only from the registers.
  - stall_o additionally asserts whenever rs or rt (nonzero) matches the EX-stage destination with ex_regwrite_o, or matches exmem_rd_i with exmem_regwrite_i.
  - No stall for MEM/WB matches: the register file writes in the first half-cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - width constants DATA_W, REG_AW, CTRL_W
  - ALU control codes: AND = 0, OR = 1, ADD = 2, SUB = 3, MUL = 4
  - forwarding-select enum: FWD_REG, FWD_EXMEM, FWD_MEMWB
- One sub-module, fwd_mux, instantiated twice (rs and rt). It does the compare/priority select and returns the value and the select.

Test Plan:
- Reset asserted mid-stream with ex_valid_o = 1 → all outputs 0 immediately, with no clock edge. First capture after release follows the normal rules.
- Sequence ADD $3,$1,$2 then SUB $4,$3,$5. EX/MEM has rd = 3, data 0x0000_0010; rs data = 0xDEAD → data1_o = 0x10.
- MEM/WB rd = 7 with 0x55, and EX/MEM rd = 7 with 0x66, both writing → data1_o = 0x66 (EX/MEM wins). With rd = 0 for both → the registered value passes through.
- LW $8 in EX, then ADD using $8 → stall_o = 1 for exactly 1 cycle. Next cycle ex_valid_o = 0 and all control is 0. The ADD is captured the following cycle.
- flush_i = 1 with id_valid_i = 1 → next cycle bubble: ex_regwrite_o = 0, ex_memwrite_o = 0.
- id_alusrc_i = 1, imm 0xFFFF_FFFC, matching EX/MEM forward on rt = 0x1234 → data2_o = 0xFFFF_FFFC and ex_store_data_o = 0x1234.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core datapath.
//   DATA_W / REG_AW / CTRL_W : operand, register-address and ALU-control widths
//   alu_op_t                 : ALU control encodings (AND=0 is also the bubble value)
//   fwd_sel_t                : operand source chosen by the forwarding muxes
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand forwarding select for one source register.
// Only present when IDEX_FORWARD_EN is defined.
//   addr            : registered source register address
//   reg_data        : registered register-file value
//   exmem_*         : EX/MEM write port (regwrite, rd, data) -- highest priority
//   memwb_*         : MEM/WB write port (regwrite, rd, data)
//   fwd_data        : selected operand value
//   sel             : selected source (fwd_sel_t encoding)
// Register 0 is never forwarded.
`ifdef IDEX_FORWARD_EN
module fwd_mux #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        sel
);
  import cpu_pkg::*;

  fwd_sel_t sel_e;

  always_comb begin
    sel_e    = FWD_REG;
    fwd_data = reg_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == addr)) begin
      sel_e    = FWD_EXMEM;
      fwd_data = exmem_data;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == addr)) begin
      sel_e    = FWD_MEMWB;
      fwd_data = memwb_data;
    end
  end

  assign sel = sel_e;

endmodule
`endif

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus operand forwarding and hazard
// detection feeding the execute ALU.
// Ports:
//   clk_i, rst_i          : clock (rising edge), asynchronous active-high reset
//   id_valid_i, flush_i   : ID holds a real instruction / load a bubble
//   id_*                  : decoded operands and control captured each cycle
//   exmem_*, memwb_*      : downstream write ports used for forwarding/hazards
//   stall_o               : combinational request to hold PC and IF/ID
//   data1_o, data2_o      : ALU operands; ALUCtrl_o : ALU control
//   ex_*                  : registered EX-stage state passed to later stages
// Build option: IDEX_FORWARD_EN enables EX/MEM and MEM/WB forwarding. When it
// is undefined, operands come straight from the registers and stall_o also
// covers RAW hazards against EX and EX/MEM (MEM/WB is covered by write-first
// register file).
module id_ex_stage #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_AW = cpu_pkg::REG_AW,
  parameter int unsigned CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_alusrc_i,
  input  logic              id_regdst_i,
  input  logic [CTRL_W-1:0] id_aluctrl_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_wr_addr_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o
);
  import cpu_pkg::*;

  logic              valid_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              alusrc_q;
  logic [CTRL_W-1:0] aluctrl_q;
  logic              regwrite_q;
  logic              memread_q;
  logic              memwrite_q;
  logic              memtoreg_q;

  logic              bubble;
  logic              load_use;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = id_valid_i && valid_q && memread_q && (wr_addr_q != '0) &&
                    ((wr_addr_q == id_rs_addr_i) || (wr_addr_q == id_rt_addr_i));

  // flush and stall together still produce a single bubble.
  assign bubble = flush_i || stall_o || !id_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      wr_addr_q  <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (bubble) begin
      // ALU control 0 is AND: a bubble computes a harmless AND of zeros.
      valid_q    <= 1'b0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      wr_addr_q  <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= 1'b1;
      rs_addr_q  <= id_rs_addr_i;
      rt_addr_q  <= id_rt_addr_i;
      wr_addr_q  <= id_regdst_i ? id_rd_addr_i : id_rt_addr_i;
      rs_data_q  <= id_rs_data_i;
      rt_data_q  <= id_rt_data_i;
      imm_q      <= id_imm_i;
      alusrc_q   <= id_alusrc_i;
      aluctrl_q  <= id_aluctrl_i;
      regwrite_q <= id_regwrite_i;
      memread_q  <= id_memread_i;
      memwrite_q <= id_memwrite_i;
      memtoreg_q <= id_memtoreg_i;
    end
  end

`ifdef IDEX_FORWARD_EN
  logic [1:0] rs_sel;
  logic [1:0] rt_sel;
  logic       unused_sel;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr           (rs_addr_q),
    .reg_data       (rs_data_q),
    .exmem_regwrite (exmem_regwrite_i),
    .exmem_rd       (exmem_rd_i),
    .exmem_data     (exmem_data_i),
    .memwb_regwrite (memwb_regwrite_i),
    .memwb_rd       (memwb_rd_i),
    .memwb_data     (memwb_data_i),
    .fwd_data       (fwd_rs),
    .sel            (rs_sel)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr           (rt_addr_q),
    .reg_data       (rt_data_q),
    .exmem_regwrite (exmem_regwrite_i),
    .exmem_rd       (exmem_rd_i),
    .exmem_data     (exmem_data_i),
    .memwb_regwrite (memwb_regwrite_i),
    .memwb_rd       (memwb_rd_i),
    .memwb_data     (memwb_data_i),
    .fwd_data       (fwd_rt),
    .sel            (rt_sel)
  );

  assign unused_sel = ^{rs_sel, rt_sel};
  assign stall_o    = load_use;
`else
  logic rs_hit;
  logic rt_hit;
  logic unused_nofwd;

  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;

  // Without forwarding, any pending write in EX or EX/MEM to a source must
  // drain before the reader may enter EX.
  assign rs_hit = (id_rs_addr_i != '0) &&
                  ((regwrite_q && (wr_addr_q == id_rs_addr_i)) ||
                   (exmem_regwrite_i && (exmem_rd_i == id_rs_addr_i)));
  assign rt_hit = (id_rt_addr_i != '0) &&
                  ((regwrite_q && (wr_addr_q == id_rt_addr_i)) ||
                   (exmem_regwrite_i && (exmem_rd_i == id_rt_addr_i)));

  assign stall_o = load_use || (id_valid_i && (rs_hit || rt_hit));

  assign unused_nofwd = ^{rs_addr_q, rt_addr_q, exmem_data_i,
                          memwb_regwrite_i, memwb_rd_i, memwb_data_i};
`endif

  assign data1_o         = fwd_rs;
  assign data2_o         = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data_o = fwd_rt;
  assign ALUCtrl_o       = aluctrl_q;
  assign ex_valid_o      = valid_q;
  assign ex_wr_addr_o    = wr_addr_q;
  assign ex_regwrite_o   = regwrite_q;
  assign ex_memread_o    = memread_q;
  assign ex_memwrite_o   = memwrite_q;
  assign ex_memtoreg_o   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Expectations follow the build option:
// with IDEX_FORWARD_EN the forwarded values are expected, otherwise the
// registered values and the extra RAW stalls.
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef IDEX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, flush_i;
  logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic        id_alusrc_i, id_regdst_i;
  logic [2:0]  id_aluctrl_i;
  logic        id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic        stall_o;
  logic [31:0] data1_o, data2_o, ex_store_data_o;
  logic [2:0]  ALUCtrl_o;
  logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
  logic [4:0]  ex_wr_addr_o;

  int unsigned n_pass;
  int unsigned n_total;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid_i), .flush_i(flush_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_alusrc_i(id_alusrc_i), .id_regdst_i(id_regdst_i), .id_aluctrl_i(id_aluctrl_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .stall_o(stall_o), .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
    .ex_valid_o(ex_valid_o), .ex_wr_addr_o(ex_wr_addr_o), .ex_store_data_o(ex_store_data_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic idle_inputs();
    id_valid_i = 1'b0; flush_i = 1'b0;
    id_rs_addr_i = '0; id_rt_addr_i = '0; id_rd_addr_i = '0;
    id_rs_data_i = '0; id_rt_data_i = '0; id_imm_i = '0;
    id_alusrc_i = 1'b0; id_regdst_i = 1'b0; id_aluctrl_i = '0;
    id_regwrite_i = 1'b0; id_memread_i = 1'b0; id_memwrite_i = 1'b0; id_memtoreg_i = 1'b0;
    exmem_regwrite_i = 1'b0; exmem_rd_i = '0; exmem_data_i = '0;
    memwb_regwrite_i = 1'b0; memwb_rd_i = '0; memwb_data_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pipe();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic alusrc, input logic regdst, input logic [2:0] ctrl,
                       input logic rw, input logic mr, input logic mw, input logic mtr);
    id_valid_i = 1'b1;
    id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd;
    id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
    id_alusrc_i = alusrc; id_regdst_i = regdst; id_aluctrl_i = ctrl;
    id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw; id_memtoreg_i = mtr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    n_total++; if (ex_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ex_valid_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_o); else n_pass++;
    rst = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++; if (ex_valid_o !== 1'b1) $display("FAIL cap_valid got=%b exp=1", ex_valid_o); else n_pass++;
    n_total++; if (ex_wr_addr_o !== 5'd3) $display("FAIL cap_wr_addr got=%0d exp=3", ex_wr_addr_o); else n_pass++;
    n_total++; if (data1_o !== 32'h11 || data2_o !== 32'h22) $display("FAIL cap_data got=%h/%h exp=00000011/00000022", data1_o, data2_o); else n_pass++;
    n_total++; if (ALUCtrl_o !== 3'd2 || ex_regwrite_o !== 1'b1) $display("FAIL cap_ctrl got=%0d/%b exp=2/1", ALUCtrl_o, ex_regwrite_o); else n_pass++;
    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    n_total++; if (ex_valid_o !== 1'b0 || ex_regwrite_o !== 1'b0) $display("FAIL async_rst_valid got=%b/%b exp=0/0", ex_valid_o, ex_regwrite_o); else n_pass++;
    n_total++; if (ex_wr_addr_o !== 5'd0 || ALUCtrl_o !== 3'd0) $display("FAIL async_rst_addr got=%0d/%0d exp=0/0", ex_wr_addr_o, ALUCtrl_o); else n_pass++;
    n_total++; if (data1_o !== 32'h0 || data2_o !== 32'h0 || ex_store_data_o !== 32'h0) $display("FAIL async_rst_data got=%h/%h/%h exp=0", data1_o, data2_o, ex_store_data_o); else n_pass++;
    #1 rst = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, ALU_OR, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    n_total++; if (ex_valid_o !== 1'b1 || ex_wr_addr_o !== 5'd2) $display("FAIL post_rst_cap got=%b/%0d exp=1/2", ex_valid_o, ex_wr_addr_o); else n_pass++;
    n_total++; if (ex_memwrite_o !== 1'b1 || ALUCtrl_o !== 3'd1) $display("FAIL post_rst_ctrl got=%b/%0d exp=1/1", ex_memwrite_o, ALUCtrl_o); else n_pass++;
  endtask

  task automatic test_fwd_exmem();
    flush_pipe();
    drive(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd3, 5'd5, 5'd4, 32'hDEAD, 32'h5, 32'h0, 1'b0, 1'b1, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_total++; if (stall_o !== !FWD) $display("FAIL add_sub_stall got=%b exp=%b", stall_o, !FWD); else n_pass++;
    flush_pipe();
    drive(5'd3, 5'd5, 5'd4, 32'hDEAD, 32'h5, 32'h0, 1'b0, 1'b1, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd3; exmem_data_i = 32'h10;
    #1;
    n_total++; if (data1_o !== (FWD ? 32'h10 : 32'hDEAD)) $display("FAIL exmem_fwd_data1 got=%h exp=%h", data1_o, FWD ? 32'h10 : 32'hDEAD); else n_pass++;
    n_total++; if (data2_o !== 32'h5) $display("FAIL exmem_fwd_data2 got=%h exp=00000005", data2_o); else n_pass++;
    n_total++; if (ex_wr_addr_o !== 5'd4 || ALUCtrl_o !== 3'd3) $display("FAIL sub_dest_ctrl got=%0d/%0d exp=4/3", ex_wr_addr_o, ALUCtrl_o); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    flush_pipe();
    drive(5'd7, 5'd0, 5'd1, 32'h99, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd7; exmem_data_i = 32'h66;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd7; memwb_data_i = 32'h55;
    #1;
    n_total++; if (data1_o !== (FWD ? 32'h66 : 32'h99)) $display("FAIL prio_exmem got=%h exp=%h", data1_o, FWD ? 32'h66 : 32'h99); else n_pass++;
    exmem_regwrite_i = 1'b0;
    #1;
    n_total++; if (data1_o !== (FWD ? 32'h55 : 32'h99)) $display("FAIL prio_memwb got=%h exp=%h", data1_o, FWD ? 32'h55 : 32'h99); else n_pass++;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
    #1;
    n_total++; if (data1_o !== 32'h99) $display("FAIL prio_rd0 got=%h exp=00000099", data1_o); else n_pass++;
    idle_inputs();
    drive(5'd0, 5'd0, 5'd1, 32'h77, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; exmem_data_i = 32'h66;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd0; memwb_data_i = 32'h55;
    #1;
    n_total++; if (data1_o !== 32'h77) $display("FAIL reg0_no_fwd got=%h exp=00000077", data1_o); else n_pass++;
  endtask

  task automatic test_load_use();
    flush_pipe();
    // LW $8, 4($1)
    drive(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    n_total++; if (ex_memread_o !== 1'b1 || ex_wr_addr_o !== 5'd8 || data2_o !== 32'h4) $display("FAIL lw_capture got=%b/%0d/%h exp=1/8/00000004", ex_memread_o, ex_wr_addr_o, data2_o); else n_pass++;
    // ADD $9, $8, $2
    drive(5'd8, 5'd2, 5'd9, 32'h0, 32'h2, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_total++; if (stall_o !== 1'b1) $display("FAIL load_use_stall got=%b exp=1", stall_o); else n_pass++;
    tick();
    n_total++; if (ex_valid_o !== 1'b0 || ex_wr_addr_o !== 5'd0) $display("FAIL lu_bubble got=%b/%0d exp=0/0", ex_valid_o, ex_wr_addr_o); else n_pass++;
    n_total++; if ({ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o} !== 4'b0 || ALUCtrl_o !== 3'd0) $display("FAIL lu_bubble_ctrl got=%b/%0d exp=0000/0", {ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o}, ALUCtrl_o); else n_pass++;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd8; exmem_data_i = 32'h104;
    #1;
`ifdef IDEX_FORWARD_EN
    n_total++; if (stall_o !== 1'b0) $display("FAIL lu_stall_once got=%b exp=0", stall_o); else n_pass++;
    tick();
    n_total++; if (ex_valid_o !== 1'b1 || ex_wr_addr_o !== 5'd9) $display("FAIL lu_add_cap got=%b/%0d exp=1/9", ex_valid_o, ex_wr_addr_o); else n_pass++;
    exmem_regwrite_i = 1'b0;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd8; memwb_data_i = 32'hABCD;
    #1;
`else
    n_total++; if (stall_o !== 1'b1) $display("FAIL nofwd_exmem_stall got=%b exp=1", stall_o); else n_pass++;
    tick();
    n_total++; if (ex_valid_o !== 1'b0) $display("FAIL nofwd_second_bubble got=%b exp=0", ex_valid_o); else n_pass++;
    exmem_regwrite_i = 1'b0;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd8; memwb_data_i = 32'hABCD;
    id_rs_data_i = 32'hABCD;
    #1;
    n_total++; if (stall_o !== 1'b0) $display("FAIL nofwd_memwb_nostall got=%b exp=0", stall_o); else n_pass++;
    tick();
    n_total++; if (ex_valid_o !== 1'b1 || ex_wr_addr_o !== 5'd9) $display("FAIL lu_add_cap got=%b/%0d exp=1/9", ex_valid_o, ex_wr_addr_o); else n_pass++;
`endif
    n_total++; if (data1_o !== 32'hABCD || data2_o !== 32'h2) $display("FAIL lu_add_data got=%h/%h exp=0000abcd/00000002", data1_o, data2_o); else n_pass++;
  endtask

  task automatic test_flush();
    flush_pipe();
    drive(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, ALU_OR, 1'b1, 1'b0, 1'b1, 1'b0);
    flush_i = 1'b1;
    tick();
    n_total++; if (ex_valid_o !== 1'b0 || ex_regwrite_o !== 1'b0 || ex_memwrite_o !== 1'b0) $display("FAIL flush_bubble got=%b/%b/%b exp=0/0/0", ex_valid_o, ex_regwrite_o, ex_memwrite_o); else n_pass++;
    flush_i = 1'b0;
    drive(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(5'd8, 5'd2, 5'd9, 32'h0, 32'h2, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    #1;
    n_total++; if (stall_o !== 1'b1) $display("FAIL flush_stall_stall got=%b exp=1", stall_o); else n_pass++;
    tick();
    n_total++; if (ex_valid_o !== 1'b0 || ex_memread_o !== 1'b0 || ex_wr_addr_o !== 5'd0) $display("FAIL flush_stall_bubble got=%b/%b/%0d exp=0/0/0", ex_valid_o, ex_memread_o, ex_wr_addr_o); else n_pass++;
    flush_i = 1'b0;
  endtask

  task automatic test_alusrc_store();
    flush_pipe();
    drive(5'd0, 5'd6, 5'd0, 32'h0, 32'h1, 32'hFFFF_FFFC, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd6; exmem_data_i = 32'h1234;
    #1;
    n_total++; if (data2_o !== 32'hFFFF_FFFC) $display("FAIL alusrc_imm got=%h exp=fffffffc", data2_o); else n_pass++;
    n_total++; if (ex_store_data_o !== (FWD ? 32'h1234 : 32'h1)) $display("FAIL store_data got=%h exp=%h", ex_store_data_o, FWD ? 32'h1234 : 32'h1); else n_pass++;
    n_total++; if (ex_memwrite_o !== 1'b1 || ex_wr_addr_o !== 5'd6) $display("FAIL sw_ctrl got=%b/%0d exp=1/6", ex_memwrite_o, ex_wr_addr_o); else n_pass++;
  endtask

  task automatic test_raw_stall();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd3, 5'd10, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_total++; if (stall_o !== !FWD) $display("FAIL raw_ex_stall got=%b exp=%b", stall_o, !FWD); else n_pass++;
    id_valid_i = 1'b0;
    #1;
    n_total++; if (stall_o !== 1'b0) $display("FAIL raw_invalid_nostall got=%b exp=0", stall_o); else n_pass++;
    drive(5'd12, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd12;
    #1;
    n_total++; if (stall_o !== !FWD) $display("FAIL raw_exmem_stall got=%b exp=%b", stall_o, !FWD); else n_pass++;
    exmem_regwrite_i = 1'b0;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd12;
    #1;
    n_total++; if (stall_o !== 1'b0) $display("FAIL raw_memwb_nostall got=%b exp=0", stall_o); else n_pass++;
    drive(5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    memwb_regwrite_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0;
    #1;
    n_total++; if (stall_o !== 1'b0) $display("FAIL raw_reg0_nostall got=%b exp=0", stall_o); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fwd_exmem();
    test_fwd_priority();
    test_load_use();
    test_flush();
    test_alusrc_store();
    test_raw_stall();
    idle_inputs();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
